// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl - iterative unsigned restoring divider controller.
//
// Produces one quotient bit per clock, MSB first, by running the partial
// remainder through a ripple borrow-chain subtractor and selecting either the
// difference or the restored value based on the final borrow.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready_o is high only in IDLE and out_valid_o only in DONE.
// Neither depends combinationally on the partner's valid/ready. Once
// out_valid_o is high, the result is held until out_ready_i is seen.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair valid
//   in_ready_o   operands accepted (IDLE only)
//   dividend_i   unsigned dividend
//   divisor_i    unsigned divisor
//   out_valid_o  result valid (DONE only)
//   out_ready_i  consumer accepts result
//   quotient_o   unsigned quotient (all ones on divide by zero)
//   remainder_o  unsigned remainder (dividend on divide by zero)
//   div0_o       divide-by-zero flag, qualified by out_valid_o
//   busy_o       iteration in progress (RUN)
module div_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div0_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div0_q, div0_d;

   // Borrow-chain row: P = {R, Q msb}, T = P - {0, D}.
   logic [WIDTH:0]   p;
   logic [WIDTH:0]   dd;
   logic [WIDTH-1:0] t;
   logic [WIDTH+1:0] b;
   logic             bo;

   always_comb begin
      p    = {r_q, q_q[WIDTH-1]};
      dd   = {1'b0, d_q};
      t    = '0;
      b    = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         if (i < WIDTH) begin
            t[i] = p[i] ^ dd[i] ^ b[i];
         end
         b[i+1] = (~p[i] & dd[i]) | (~(p[i] ^ dd[i]) & b[i]);
      end
      bo = b[WIDTH+1];
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      div0_d  = div0_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               if (divisor_i != '0) begin
                  q_d     = dividend_i;
                  d_d     = divisor_i;
                  r_d     = '0;
                  cnt_d   = CW'(WIDTH);
                  div0_d  = 1'b0;
                  state_d = S_RUN;
               end else begin
                  // Divide by zero skips iteration entirely.
                  q_d     = '1;
                  r_d     = dividend_i;
                  div0_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            // A borrow means P < D: keep P (restore) and shift in a 0.
            r_d   = bo ? p[WIDTH-1:0] : t;
            q_d   = {q_q[WIDTH-2:0], ~bo};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         div0_q  <= div0_d;
      end
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q == S_RUN);
   assign quotient_o  = q_q;
   assign remainder_o = r_q;
   assign div0_o      = div0_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl - directed and random bench for div_seq_ctrl (WIDTH=8).
module tb_div_seq_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div0;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected results: pushed at accept, popped when the result is checked.
   logic [2*W:0] exp_q[$];

   div_seq_ctrl #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .div0_o      (div0),
      .busy_o      (busy)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Driver: present a/b, wait for the result, check latency, busy length
   // and result, optionally stall the consumer, then hand the result off.
   // spam keeps in_valid high with 50/5 while the operation is in flight.
   task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int stall, input bit spam);
      int           lat;
      int           busy_cnt;
      logic [2*W:0] e;
      exp_q.push_back({ez, eq, er});
      check({tag, ".in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      if (spam) begin
         dividend = 8'd50;
         divisor  = 8'd5;
      end else begin
         in_valid = 1'b0;
      end
      lat      = 1;
      busy_cnt = 0;
      while (!out_valid && lat < 40) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      in_valid = 1'b0;
      e = exp_q.pop_front();
      check({tag, ".latency"}, lat, ez ? 1 : W + 1);
      check({tag, ".busy_cycles"}, busy_cnt, ez ? 0 : W);
      if (!out_valid) begin
         check({tag, ".timeout"}, out_valid, 1);
         return;
      end
      check({tag, ".quotient"}, quotient, e[2*W-1:W]);
      check({tag, ".remainder"}, remainder, e[W-1:0]);
      check({tag, ".div0"}, div0, e[2*W]);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, ".hold_valid"}, out_valid, 1);
         check({tag, ".hold_q"}, quotient, e[2*W-1:W]);
         check({tag, ".hold_r"}, remainder, e[W-1:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".ready_after"}, in_ready, 1);
      check({tag, ".valid_after"}, out_valid, 0);
   endtask

   // Random sweep: expectations come from the bench's own arithmetic.
   task automatic rand_div(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid) begin
         check("rand.timeout", out_valid, 1);
         return;
      end
      if (b == 0) begin
         check("rand.div0_q", {div0, quotient}, {1'b1, 8'hFF});
         check("rand.div0_r", remainder, a);
      end else begin
         check("rand.invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         check("rand.rem_lt_div", (remainder < b) ? 1 : 0, 1);
         check("rand.quotient", quotient, a / b);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("reset.in_ready", in_ready, 1);
      check("reset.out_valid", out_valid, 0);
      check("reset.busy", busy, 0);
      check("reset.quotient", quotient, 0);
      check("reset.remainder", remainder, 0);
      check("reset.div0", div0, 0);

      // Basic and boundary divisions
      do_div("t1_100_7",  8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 0, 1'b0);
      do_div("t2_255_1",  8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 0, 1'b0);
      do_div("t2_5_9",    8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 0, 1'b0);
      do_div("t2_255_255",8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 0, 1'b0);
      do_div("t2_0_3",    8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 0, 1'b0);
      // Divide by zero
      do_div("t3_37_0",   8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 0, 1'b0);
      // Backpressure
      do_div("t4_200_13", 8'd200, 8'd13,  8'd15,  8'd5, 1'b0, 5, 1'b0);
      // Busy rejection, then the rejected operands accepted normally
      do_div("t5_first",  8'd200, 8'd13,  8'd15,  8'd5, 1'b0, 0, 1'b1);
      do_div("t5_50_5",   8'd50,  8'd5,   8'd10,  8'd0, 1'b0, 0, 1'b0);

      // Reset during RUN cycle 4
      in_valid = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("t6.busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6.in_ready", in_ready, 1);
      check("t6.out_valid", out_valid, 0);
      check("t6.busy", busy, 0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
         end
         check("t6.no_result", seen, 0);
      end

      // Reset and in_valid together: nothing accepted
      rst      = 1'b1;
      in_valid = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd3;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("t6.rst_win_busy", busy, 0);
      check("t6.rst_win_ready", in_ready, 1);

      // Random sweep
      for (int n = 0; n < 2000; n++) begin
         rand_div(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
